// File: rtl/bcd_ascii_serializer.sv
// bcd_ascii_serializer
//   Takes one decimal result as three BCD digits and streams it out as ASCII
//   characters, one per out_valid/out_ready handshake.
//
//   Parameter LZ_SUPPRESS : 1 = drop leading zero digits (units always sent),
//                           0 = always send three digits.
//   Macro SERIALIZER_CRLF_EN : when defined, each frame ends with CR (0x0D)
//                              and LF (0x0A), each with its own handshake.
//
//   Ports
//     clk, rst_n          clock (rising edge), async active-low reset
//     in_valid/in_ready   digit-triple handshake (ready only while idle)
//     centenas/decenas/unidades  hundreds/tens/units BCD digits
//     out_valid/out_ready character handshake
//     out_data            ASCII character (digits >9 shown as '?')
//     busy                a frame is in progress
//     err                 current frame holds a non-BCD digit
module bcd_ascii_serializer #(
   parameter int LZ_SUPPRESS = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] centenas,
   input  logic [3:0] decenas,
   input  logic [3:0] unidades,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       busy,
   output logic       err
);

`ifdef SERIALIZER_CRLF_EN
   typedef enum logic [2:0] {IDLE, CEN, DEC, UNI, CR, LF} state_t;
`else
   typedef enum logic [1:0] {IDLE, CEN, DEC, UNI} state_t;
`endif

   state_t     state_q, state_d;
   logic [3:0] cen_q, dec_q, uni_q;
   logic [7:0] data_q, data_d;
   logic       valid_q;
   logic       xfer, accept;

   function automatic logic [7:0] enc(input logic [3:0] d);
      return (d > 4'd9) ? 8'h3F : {4'h3, d};
   endfunction

   assign xfer   = valid_q & out_ready;
   assign accept = in_valid & (state_q == IDLE);

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               // First character is picked from the live inputs so it is
               // already on out_data the cycle after acceptance.
               if ((LZ_SUPPRESS == 0) || (centenas != 4'd0)) begin
                  state_d = CEN;
                  data_d  = enc(centenas);
               end else if (decenas != 4'd0) begin
                  state_d = DEC;
                  data_d  = enc(decenas);
               end else begin
                  state_d = UNI;
                  data_d  = enc(unidades);
               end
            end
         end
         CEN: if (xfer) begin
            state_d = DEC;
            data_d  = enc(dec_q);
         end
         DEC: if (xfer) begin
            state_d = UNI;
            data_d  = enc(uni_q);
         end
`ifdef SERIALIZER_CRLF_EN
         UNI: if (xfer) begin
            state_d = CR;
            data_d  = 8'h0D;
         end
         CR: if (xfer) begin
            state_d = LF;
            data_d  = 8'h0A;
         end
         LF: if (xfer) begin
            state_d = IDLE;
            data_d  = 8'h00;
         end
`else
         UNI: if (xfer) begin
            state_d = IDLE;
            data_d  = 8'h00;
         end
`endif
         default: begin
            state_d = IDLE;
            data_d  = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         cen_q   <= 4'd0;
         dec_q   <= 4'd0;
         uni_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= (state_d != IDLE);
         if (accept) begin
            cen_q <= centenas;
            dec_q <= decenas;
            uni_q <= unidades;
         end
      end
   end

   // The digit registers only change on acceptance or reset, so deriving err
   // from them gives exactly the sticky-until-next-frame behaviour.
   assign err       = (cen_q > 4'd9) | (dec_q > 4'd9) | (uni_q > 4'd9);
   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule
